// File: rtl/spi_cmd_decoder.sv
// Purpose: frames SPI bytes by chip-enable and decodes INC/DEC/LOAD/READ/ADD against a counter.
// Latency: count/tx_byte/tx_load registered 1 clk after the rx_valid completing a byte's action.
// Backpressure: none; rx_valid strobes are consumed or ignored, tx_load is a 1-clk strobe.
// Optional: define COUNTER_SAT_EN for saturating counter arithmetic (default build wraps).
module spi_cmd_decoder #(
  parameter int         CNT_W    = 8,
  parameter logic [7:0] ACK_BYTE = 8'hA5,
  parameter logic [7:0] NAK_BYTE = 8'h5A
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  output logic [7:0]       tx_byte,
  output logic             tx_load,
  output logic [CNT_W-1:0] count,
  output logic             cmd_err
);

  localparam logic [7:0] OP_INC  = 8'h01;
  localparam logic [7:0] OP_DEC  = 8'h02;
  localparam logic [7:0] OP_LOAD = 8'h03;
  localparam logic [7:0] OP_READ = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CMD, ARG, DONE} state_t;

  state_t           state;
  logic             cs_meta;
  logic             cs_sync;
  logic             cs_prev;
  logic             op_is_add;
  logic [CNT_W-1:0] arg_zx;
  logic [CNT_W-1:0] inc_val;
  logic [CNT_W-1:0] dec_val;
  logic [CNT_W-1:0] add_val;

`ifdef COUNTER_SAT_EN
  logic [CNT_W:0] inc_wide;
  logic [CNT_W:0] add_wide;
`endif

  // Zero-extend the received byte to counter width.
  always_comb begin
    arg_zx      = '0;
    arg_zx[7:0] = rx_byte;
  end

  // Candidate next counter values; saturating build clamps at both ends.
  always_comb begin
`ifdef COUNTER_SAT_EN
    inc_wide = {1'b0, count} + {1'b0, ONE};
    add_wide = {1'b0, count} + {1'b0, arg_zx};
    inc_val  = inc_wide[CNT_W] ? {CNT_W{1'b1}} : inc_wide[CNT_W-1:0];
    add_val  = add_wide[CNT_W] ? {CNT_W{1'b1}} : add_wide[CNT_W-1:0];
    dec_val  = (count == '0) ? '0 : count - ONE;
`else
    inc_val  = count + ONE;
    add_val  = count + arg_zx;
    dec_val  = count - ONE;
`endif
  end

  // cs_n synchroniser, framing FSM, counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      state     <= IDLE;
      op_is_add <= 1'b0;
      count     <= '0;
      tx_byte   <= 8'h00;
      tx_load   <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cs_meta <= cs_n;
      cs_sync <= cs_meta;
      cs_prev <= cs_sync;
      tx_load <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_prev && !cs_sync) state <= CMD;
        end
        CMD: begin
          if (rx_valid) begin
            tx_load <= 1'b1;
            case (rx_byte)
              OP_INC: begin
                count   <= inc_val;
                tx_byte <= ACK_BYTE;
                cmd_err <= 1'b0;
                state   <= DONE;
              end
              OP_DEC: begin
                count   <= dec_val;
                tx_byte <= ACK_BYTE;
                cmd_err <= 1'b0;
                state   <= DONE;
              end
              OP_READ: begin
                tx_byte <= count[7:0];
                cmd_err <= 1'b0;
                state   <= DONE;
              end
              OP_LOAD, OP_ADD: begin
                op_is_add <= (rx_byte == OP_ADD);
                tx_byte   <= ACK_BYTE;
                cmd_err   <= 1'b0;
                state     <= ARG;
              end
              default: begin
                tx_byte <= NAK_BYTE;
                cmd_err <= 1'b1;
                state   <= DONE;
              end
            endcase
          end
        end
        ARG: begin
          if (rx_valid) begin
            tx_load <= 1'b1;
            tx_byte <= ACK_BYTE;
            count   <= op_is_add ? add_val : arg_zx;
            state   <= DONE;
          end
        end
        default: begin
          // DONE: trailing bytes in the frame are dropped.
        end
      endcase

      // Chip-enable release ends the frame after any byte this cycle is handled.
      if (state != IDLE && cs_sync) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Purpose: self-checking bench for spi_cmd_decoder: directed frame table, corner sequences, random frames.
// Latency: checks outputs at the falling edge following each rx_valid sample edge.
// Backpressure: none; stimulus paced by fixed cycle counts only.
module tb_spi_cmd_decoder;

  localparam int         CNT_W = 8;
  localparam int         MODV  = 1 << CNT_W;
  localparam int         MAXV  = MODV - 1;
  localparam logic [7:0] ACK   = 8'hA5;
  localparam logic [7:0] NAK   = 8'h5A;
`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cs_n = 1'b1;
  logic [7:0]       rx_byte = 8'h00;
  logic             rx_valid = 1'b0;
  logic [7:0]       tx_byte;
  logic             tx_load;
  logic [CNT_W-1:0] count;
  logic             cmd_err;

  int tests = 0;
  int fails = 0;

  // reference model state
  int         m_cnt = 0;
  logic [7:0] m_tx  = 8'h00;
  logic       m_err = 1'b0;
  bit         m_act = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_op  = 8'h00;

  always #5 clk = ~clk;

  spi_cmd_decoder #(.CNT_W(CNT_W), .ACK_BYTE(ACK), .NAK_BYTE(NAK)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_load(tx_load), .count(count), .cmd_err(cmd_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int fix(input int v);
    if (SAT) return (v > MAXV) ? MAXV : ((v < 0) ? 0 : v);
    return ((v % MODV) + MODV) % MODV;
  endfunction

  // Command semantics applied byte by byte within a frame.
  task automatic model_byte(input logic [7:0] b, output logic ld);
    ld = 1'b0;
    if (!m_act || m_pos == 2) return;
    ld = 1'b1;
    if (m_pos == 0) begin
      m_err = 1'b0;
      m_tx  = ACK;
      m_pos = 2;
      case (b)
        8'h01: m_cnt = fix(m_cnt + 1);
        8'h02: m_cnt = fix(m_cnt - 1);
        8'h04: m_tx = 8'(m_cnt % 256);
        8'h03, 8'h05: begin m_op = b; m_pos = 1; end
        default: begin m_tx = NAK; m_err = 1'b1; end
      endcase
    end else begin
      m_tx  = ACK;
      m_cnt = (m_op == 8'h03) ? int'(b) : fix(m_cnt + int'(b));
      m_pos = 2;
    end
  endtask

  task automatic check_after(input logic ld);
    chk("tx_load", 32'(tx_load), 32'(ld));
    if (ld) chk("tx_byte", 32'(tx_byte), 32'(m_tx));
    chk("count", 32'(count), 32'(m_cnt));
    chk("cmd_err", 32'(cmd_err), 32'(m_err));
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ld;
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    model_byte(b, ld);
    check_after(ld);
  endtask

  task automatic start_frame();
    @(negedge clk);
    cs_n  = 1'b0;
    m_act = 1'b1;
    m_pos = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    cs_n  = 1'b1;
    m_act = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_tx_load", 32'(tx_load), 32'd0);
  endtask

  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2;
    logic [7:0] e_cnt, e_tx;
    logic       e_err;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] c, input logic [7:0] t,
                              input logic e);
    vec_t v;
    v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.e_cnt = c; v.e_tx = t; v.e_err = e;
    return v;
  endfunction

  initial begin
    logic [7:0] bytes[3];
    logic       ld;

    vt[0]  = mk(1, 8'h01, 8'h00, 8'h00, 8'h01, ACK, 1'b0);
    vt[1]  = mk(1, 8'h01, 8'h00, 8'h00, 8'h02, ACK, 1'b0);
    vt[2]  = mk(1, 8'h01, 8'h00, 8'h00, 8'h03, ACK, 1'b0);
    vt[3]  = mk(2, 8'h03, 8'hFE, 8'h00, 8'hFE, ACK, 1'b0);
    vt[4]  = mk(1, 8'h01, 8'h00, 8'h00, 8'hFF, ACK, 1'b0);
    vt[5]  = mk(1, 8'h01, 8'h00, 8'h00, SAT ? 8'hFF : 8'h00, ACK, 1'b0);
    vt[6]  = mk(2, 8'h03, 8'h42, 8'h00, 8'h42, ACK, 1'b0);
    vt[7]  = mk(3, 8'h04, 8'h00, 8'h00, 8'h42, 8'h42, 1'b0);
    vt[8]  = mk(2, 8'h03, 8'h20, 8'h00, 8'h20, ACK, 1'b0);
    vt[9]  = mk(1, 8'h05, 8'h00, 8'h00, 8'h20, ACK, 1'b0);
    vt[10] = mk(2, 8'h05, 8'h10, 8'h00, 8'h30, ACK, 1'b0);
    vt[11] = mk(2, 8'h03, 8'h00, 8'h00, 8'h00, ACK, 1'b0);
    vt[12] = mk(1, 8'h77, 8'h00, 8'h00, 8'h00, NAK, 1'b1);
    vt[13] = mk(1, 8'h02, 8'h00, 8'h00, SAT ? 8'h00 : 8'hFF, ACK, 1'b0);

    // reset state
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_tx_load", 32'(tx_load), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed frame table
    for (int i = 0; i < 14; i++) begin
      bytes[0] = vt[i].b0; bytes[1] = vt[i].b1; bytes[2] = vt[i].b2;
      start_frame();
      for (int k = 0; k < vt[i].n; k++) send_byte(bytes[k]);
      end_frame();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_cnt));
      chk($sformatf("vec%0d_tx_byte", i), 32'(tx_byte), 32'(vt[i].e_tx));
      chk($sformatf("vec%0d_cmd_err", i), 32'(cmd_err), 32'(vt[i].e_err));
    end

    // byte arriving in the same cycle as the synced cs_n rise is still processed
    start_frame();
    @(negedge clk);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    rx_byte  = 8'h01;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    model_byte(8'h01, ld);
    check_after(ld);
    m_act = 1'b0;
    repeat (2) @(negedge clk);
    // byte while idle is ignored
    send_byte(8'h01);

    // reset mid-frame after loading 0x37, with an ADD pending
    start_frame();
    send_byte(8'h03);
    send_byte(8'h37);
    end_frame();
    start_frame();
    send_byte(8'h05);
    chk("pre_rst_count", 32'(count), 32'h37);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("mid_rst_cmd_err", 32'(cmd_err), 32'd0);
    chk("mid_rst_tx_load", 32'(tx_load), 32'd0);
    m_cnt = 0; m_tx = 8'h00; m_err = 1'b0; m_act = 1'b0;
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h10);   // FSM idle: the pending ADD must not complete

    // randomized frames against the model
    for (int f = 0; f < 150; f++) begin
      int nb;
      start_frame();
      nb = $urandom_range(0, 4);
      for (int k = 0; k < nb; k++) begin
        logic [7:0] b;
        int r;
        r = $urandom_range(0, 7);
        if (k == 0 && r <= 5) b = 8'(r);
        else b = 8'($urandom);
        send_byte(b);
      end
      end_frame();
      if ($urandom_range(0, 4) == 0) send_byte(8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
